gpr_mp: RTL and testbench

Parametrised multi-port general-purpose register file with an integrated write-pending scoreboard. It is used by the decode/issue stage: it provides NUM_RD combinational read ports with same-cycle write bypass, and NUM_WR write ports from the writeback lanes. It tracks which registers have an in-flight producer, so issue logic can stall on read-after-write hazards. x0 is hardwired to zero, and a runtime debug read port replaces the fixed ra tap.

---
 rtl/gpr_mp_pkg.sv | 8 +
 rtl/gpr_scoreboard.sv | 74 +++++++
 rtl/gpr_mp.sv | 80 ++++++++
 tb/tb_gpr_mp.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_mp_pkg.sv
// Shared widths and parameter defaults for the multi-port GPR file and its scoreboard.
package gpr_mp_pkg;

  localparam int unsigned WORD_WIDTH     = 32;
  localparam int unsigned GPR_ADDR_WIDTH = 5;
  localparam int unsigned DATA_HIGH_GPR  = 32;

endpackage

// File: rtl/gpr_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, with issue/write/flush priority,
// per-read-port busy reporting and a population count.
module gpr_scoreboard
  import gpr_mp_pkg::*;
#(
  parameter int unsigned NUM_REGS = DATA_HIGH_GPR,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [CNT_W-1:0]         busy_cnt
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] iss_hit;

  // Decode loops start at 1 so x0 never gets a hit and its busy bit stays 0.
  always_comb begin
    wr_hit  = '0;
    iss_hit = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      iss_hit[r] = issue_en && (issue_addr == ADDR_W'(r));
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r)))
          wr_hit[r] = 1'b1;
      end
    end
  end

  // A new issue supersedes a completing write to the same register.
  always_comb begin
    if (flush)
      busy_nxt = '0;
    else
      busy_nxt = (busy | iss_hit) & ~(wr_hit & ~iss_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  always_comb begin
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_busy[i] = busy[rd_addr[i*ADDR_W +: ADDR_W]];
      if ((BYPASS != 0) && wr_hit[rd_addr[i*ADDR_W +: ADDR_W]]
          && !iss_hit[rd_addr[i*ADDR_W +: ADDR_W]])
        rd_busy[i] = 1'b0;
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++)
      busy_cnt = busy_cnt + CNT_W'(busy[r]);
  end

endmodule

// File: rtl/gpr_mp.sv
// Multi-port general-purpose register file: storage, write arbitration, read/bypass muxes,
// debug read tap and an embedded write-pending scoreboard.
module gpr_mp
  import gpr_mp_pkg::*;
#(
  parameter int unsigned XLEN     = WORD_WIDTH,
  parameter int unsigned NUM_REGS = DATA_HIGH_GPR,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]       wr_addr,
  input  logic [NUM_WR*XLEN-1:0]         wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]       rd_addr,
  output logic [NUM_RD*XLEN-1:0]         rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic                           issue_en,
  input  logic [ADDR_W-1:0]              issue_addr,
  input  logic                           flush,
  output logic [$clog2(NUM_REGS+1)-1:0]  busy_cnt,
  input  logic [ADDR_W-1:0]              dbg_addr,
  output logic [XLEN-1:0]                dbg_data
);

  logic [XLEN-1:0] regs [NUM_REGS];

  // Ascending port order makes the last non-blocking assignment, the highest port, win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] != '0))
          regs[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*ADDR_W +: ADDR_W]];
      if (BYPASS != 0) begin
        for (int unsigned k = 0; k < NUM_WR; k++) begin
          if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W]))
            rd_data[i*XLEN +: XLEN] = wr_data[k*XLEN +: XLEN];
        end
      end
      if (rd_addr[i*ADDR_W +: ADDR_W] == '0)
        rd_data[i*XLEN +: XLEN] = '0;
    end
  end

  assign dbg_data = regs[dbg_addr];

  gpr_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .flush      (flush),
    .rd_busy    (rd_busy),
    .busy_cnt   (busy_cnt)
  );

endmodule

// File: tb/tb_gpr_mp.sv
// Bench for gpr_mp: two instances (bypass on/off) share stimulus; expectations are queued
// at drive time and compared on the falling edge.
module tb_gpr_mp;

  localparam int XL = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*XL-1:0] wr_data;
  logic [2*AW-1:0] rd_addr;
  logic          issue_en;
  logic [AW-1:0] issue_addr;
  logic          flush;
  logic [AW-1:0] dbg_addr;

  logic [2*XL-1:0] rd_data_b, rd_data_n;
  logic [1:0]      rd_busy_b, rd_busy_n;
  logic [5:0]      cnt_b, cnt_n;
  logic [XL-1:0]   dbg_b, dbg_n;

  always #5 clk = ~clk;

  gpr_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b), .issue_en(issue_en),
    .issue_addr(issue_addr), .flush(flush), .busy_cnt(cnt_b), .dbg_addr(dbg_addr),
    .dbg_data(dbg_b)
  );

  gpr_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n), .issue_en(issue_en),
    .issue_addr(issue_addr), .flush(flush), .busy_cnt(cnt_n), .dbg_addr(dbg_addr),
    .dbg_data(dbg_n)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic [4:0]  da;
    logic [31:0] rd0, rd1, nrd0;
    logic [1:0]  busy, nbusy;
    logic [5:0]  cnt;
    logic [31:0] dbg;
  } vec_t;

  vec_t tbl [21];
  vec_t expq [$];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [NR];
  logic        m_busy [NR];

  function automatic vec_t mk(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic ie, input logic [4:0] ia, input logic fl,
                              input logic [4:0] da, input logic [31:0] rd0,
                              input logic [31:0] rd1, input logic [31:0] nrd0,
                              input logic [1:0] busy, input logic [1:0] nbusy,
                              input logic [5:0] cnt, input logic [31:0] dbg);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.ie = ie; v.ia = ia; v.fl = fl; v.da = da;
    v.rd0 = rd0; v.rd1 = rd1; v.nrd0 = nrd0; v.busy = busy; v.nbusy = nbusy;
    v.cnt = cnt; v.dbg = dbg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of the spec behaviour, used for the randomised phase.
  function automatic logic written(input vec_t v, input logic [4:0] a);
    return (v.we[0] && v.wa0 == a) || (v.we[1] && v.wa1 == a);
  endfunction

  function automatic logic [31:0] m_read(input vec_t v, input logic [4:0] a, input bit byp);
    logic [31:0] d;
    if (a == 0) return 32'h0;
    d = m_regs[a];
    if (byp) begin
      if (v.we[0] && v.wa0 == a) d = v.wd0;
      if (v.we[1] && v.wa1 == a) d = v.wd1;
    end
    return d;
  endfunction

  function automatic logic m_rbusy(input vec_t v, input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && written(v, a) && !(v.ie && v.ia == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic vec_t m_expect(input vec_t v);
    vec_t e = v;
    int c = 0;
    e.rd0   = m_read(v, v.ra0, 1'b1);
    e.rd1   = m_read(v, v.ra1, 1'b1);
    e.nrd0  = m_read(v, v.ra0, 1'b0);
    e.busy  = {m_rbusy(v, v.ra1, 1'b1), m_rbusy(v, v.ra0, 1'b1)};
    e.nbusy = {m_rbusy(v, v.ra1, 1'b0), m_rbusy(v, v.ra0, 1'b0)};
    for (int r = 0; r < NR; r++) c += int'(m_busy[r]);
    e.cnt = 6'(c);
    e.dbg = m_regs[v.da];
    return e;
  endfunction

  task automatic m_update(input vec_t v);
    for (int r = 1; r < NR; r++) begin
      if (v.fl) m_busy[r] = 1'b0;
      else if (v.ie && v.ia == 5'(r)) m_busy[r] = 1'b1;
      else if (written(v, 5'(r))) m_busy[r] = 1'b0;
    end
    if (v.we[0] && v.wa0 != 0) m_regs[v.wa0] = v.wd0;
    if (v.we[1] && v.wa1 != 0) m_regs[v.wa1] = v.wd1;
  endtask

  task automatic m_reset();
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = 32'h0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic drive(input vec_t v);
    wr_en      = v.we;
    wr_addr    = {v.wa1, v.wa0};
    wr_data    = {v.wd1, v.wd0};
    rd_addr    = {v.ra1, v.ra0};
    issue_en   = v.ie;
    issue_addr = v.ia;
    flush      = v.fl;
    dbg_addr   = v.da;
  endtask

  task automatic compare_pop();
    vec_t e;
    if (expq.size() == 0) begin
      chk("queue_empty", 32'h1, 32'h0);
      return;
    end
    e = expq.pop_front();
    chk("rd0",        rd_data_b[31:0],  e.rd0);
    chk("rd1",        rd_data_b[63:32], e.rd1);
    chk("rd0_nobyp",  rd_data_n[31:0],  e.nrd0);
    chk("rd_busy",    32'(rd_busy_b),   32'(e.busy));
    chk("rd_busy_nb", 32'(rd_busy_n),   32'(e.nbusy));
    chk("busy_cnt",   32'(cnt_b),       32'(e.cnt));
    chk("busy_cnt_nb", 32'(cnt_n),      32'(e.cnt));
    chk("dbg_data",   dbg_b,            e.dbg);
  endtask

  // Called just after a rising edge: drive, compare on the falling edge, advance a cycle.
  task automatic step(input vec_t v);
    drive(v);
    expq.push_back(v);
    @(negedge clk);
    compare_pop();
    m_update(v);
    @(posedge clk);
    #1;
  endtask

  task automatic step_model(input vec_t v);
    step(m_expect(v));
  endtask

  function automatic vec_t idle(input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] da);
    return mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, ra0, ra1, 1'b0, 5'd0, 1'b0, da,
              32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 6'd0, 32'h0);
  endfunction

  initial begin
    vec_t v;
    rst_n = 1'b0;
    drive(idle(5'd0, 5'd0, 5'd0));
    m_reset();

    //        we  wa0 wd0           wa1 wd1   ra0 ra1 ie ia fl da  rd0           rd1           nrd0          bsy nbsy cnt dbg
    tbl[0]  = mk(0, 0, 0,            0, 0,     5, 0,  0, 0, 0, 5,  0,            0,            0,            0, 0, 0, 0);
    tbl[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0,     5, 0,  0, 0, 0, 5,  32'hDEADBEEF, 0,            0,            0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,            0, 0,     5, 0,  0, 0, 0, 5,  32'hDEADBEEF, 0,            32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF);
    tbl[3]  = mk(1, 0, 32'h1234,     0, 0,     0, 5,  1, 0, 0, 0,  0,            32'hDEADBEEF, 0,            0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0,            0, 0,     0, 5,  0, 0, 0, 0,  0,            32'hDEADBEEF, 0,            0, 0, 0, 0);
    tbl[5]  = mk(3, 7, 32'h11,       7, 32'h22, 7, 7, 0, 0, 0, 7,  32'h22,       32'h22,       0,            0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0,            0, 0,     7, 5,  0, 0, 0, 7,  32'h22,       32'hDEADBEEF, 32'h22,       0, 0, 0, 32'h22);
    tbl[7]  = mk(0, 0, 0,            0, 0,     3, 7,  1, 3, 0, 3,  0,            32'h22,       0,            0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0,            0, 0,     3, 7,  0, 0, 0, 3,  0,            32'h22,       0,            1, 1, 1, 0);
    tbl[9]  = tbl[8];
    tbl[10] = tbl[8];
    tbl[11] = mk(1, 3, 32'hAB,       0, 0,     3, 7,  0, 0, 0, 3,  32'hAB,       32'h22,       0,            0, 1, 1, 0);
    tbl[12] = mk(0, 0, 0,            0, 0,     3, 7,  0, 0, 0, 3,  32'hAB,       32'h22,       32'hAB,       0, 0, 0, 32'hAB);
    tbl[13] = mk(1, 9, 32'h99,       0, 0,     9, 3,  1, 9, 0, 9,  32'h99,       32'hAB,       0,            0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0,            0, 0,     9, 3,  0, 0, 0, 9,  32'h99,       32'hAB,       32'h99,       1, 1, 1, 32'h99);
    tbl[15] = mk(1, 9, 32'h55,       0, 0,     9, 3,  1, 9, 0, 9,  32'h55,       32'hAB,       32'h99,       1, 1, 1, 32'h99);
    tbl[16] = mk(0, 0, 0,            0, 0,     2, 9,  1, 2, 0, 9,  0,            32'h55,       0,            2, 2, 1, 32'h55);
    tbl[17] = mk(0, 0, 0,            0, 0,     2, 9,  1, 4, 0, 9,  0,            32'h55,       0,            3, 3, 2, 32'h55);
    tbl[18] = mk(0, 0, 0,            0, 0,     2, 9,  1, 6, 0, 9,  0,            32'h55,       0,            3, 3, 3, 32'h55);
    tbl[19] = mk(0, 0, 0,            0, 0,     2, 9,  1, 8, 1, 9,  0,            32'h55,       0,            3, 3, 4, 32'h55);
    tbl[20] = mk(0, 0, 0,            0, 0,     8, 9,  0, 0, 0, 9,  0,            32'h55,       0,            0, 0, 0, 32'h55);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) step(tbl[i]);

    for (int n = 0; n < 400; n++) begin
      v = idle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      v.we  = 2'($urandom_range(0, 3));
      v.wa0 = 5'($urandom_range(0, 7));
      v.wa1 = 5'($urandom_range(0, 7));
      v.wd0 = $urandom;
      v.wd1 = $urandom;
      v.ie  = ($urandom_range(0, 1) == 1);
      v.ia  = 5'($urandom_range(0, 7));
      v.fl  = ($urandom_range(0, 15) == 0);
      step_model(v);
    end

    // Async reset mid-cycle with three busy registers and non-zero storage.
    v = idle(5'd0, 5'd0, 5'd0);
    v.fl = 1'b1;
    step_model(v);
    v = idle(5'd5, 5'd7, 5'd5);
    v.we = 2'b01; v.wa0 = 5'd5; v.wd0 = 32'h5555_AAAA; v.ie = 1'b1; v.ia = 5'd3;
    step_model(v);
    v = idle(5'd5, 5'd7, 5'd5);
    v.ie = 1'b1; v.ia = 5'd5;
    step_model(v);
    v = idle(5'd5, 5'd7, 5'd5);
    v.ie = 1'b1; v.ia = 5'd7;
    step_model(v);
    drive(idle(5'd5, 5'd3, 5'd5));
    #1;
    chk("pre_reset_cnt", 32'(cnt_b), 32'd3);
    chk("pre_reset_rd",  rd_data_b[31:0], 32'h5555_AAAA);
    rst_n = 1'b0;
    #1;
    chk("arst_cnt",     32'(cnt_b), 32'd0);
    chk("arst_cnt_nb",  32'(cnt_n), 32'd0);
    chk("arst_rd0",     rd_data_b[31:0], 32'h0);
    chk("arst_rd0_nb",  rd_data_n[31:0], 32'h0);
    chk("arst_dbg",     dbg_b, 32'h0);
    chk("arst_busy",    32'(rd_busy_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    step_model(idle(5'd5, 5'd7, 5'd5));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
